// File: rtl/duv_resp_monitor.sv
// duv_resp_monitor: timestamps changes of {out_a,out_b} into a FWFT event FIFO drained by valid/ready.
// Define MON_GLITCH_FILTER_EN to record only values sampled identically on two consecutive edges.
module duv_resp_monitor #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            mon_en,
  input  logic [1:0]      out_a,
  input  logic [1:0]      out_b,
  input  logic            evt_ready,
  output logic            evt_valid,
  output logic [TS_W+3:0] evt_data,
  input  logic            ovf_clr,
  output logic            overflow,
  output logic [7:0]      drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = TS_W + 4;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [3:0]      cur, prev_q, prev_d;
  logic [DW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [DW-1:0]   head_q, head_d, entry;
  logic            ovf_q, ovf_d;
  logic [7:0]      drop_q, drop_d;
  logic            push_req, push, pop, full, drop;

  assign cur   = {out_a, out_b};
  assign entry = {ts_q, cur};

`ifdef MON_GLITCH_FILTER_EN
  // prev holds the last stable value; cand holds the previous raw sample
  logic [3:0] cand_q;
  assign push_req = mon_en && cur == cand_q && cur != prev_q;
  assign prev_d   = cur == cand_q ? cur : prev_q;
  always_ff @(posedge clk or posedge arst)
    if (arst) cand_q <= '0;
    else      cand_q <= cur;
`else
  assign push_req = mon_en && cur != prev_q;
  assign prev_d   = cur;
`endif

  always_comb begin
    full      = cnt_q == (AW+1)'(DEPTH);
    evt_valid = cnt_q != '0;
    pop       = evt_valid && evt_ready;
    push      = push_req && (!full || pop);
    drop      = push_req && full && !pop;
    wr_d      = wr_q + AW'(push);
    rd_d      = rd_q + AW'(pop);
    cnt_d     = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    // head register tracks the next head, bypassing the entry written this edge
    head_d    = cnt_d == '0 ? head_q : (push && rd_d == wr_q) ? entry : mem_q[rd_d];
    ts_d      = mon_en ? ts_q + TS_W'(1) : ts_q;
    ovf_d     = drop | (ovf_q & ~ovf_clr);
    drop_d    = drop ? (ovf_clr ? 8'd1 : (&drop_q ? drop_q : drop_q + 8'd1))
                     : (ovf_clr ? 8'd0 : drop_q);
  end

  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= entry;

  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      ts_q   <= '0;
      prev_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      ts_q   <= ts_d;
      prev_q <= prev_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end

  assign evt_data = head_q;
  assign overflow = ovf_q;
  assign drop_cnt = drop_q;
endmodule

// File: tb/tb_duv_resp_monitor.sv
// tb_duv_resp_monitor: directed self-checking bench; second instance with TS_W=4 covers timestamp wrap.
module tb_duv_resp_monitor;
  logic        clk = 1'b0;
  logic        arst, mon_en, evt_ready, ovf_clr;
  logic [1:0]  out_a, out_b;
  logic        evt_valid, overflow;
  logic [19:0] evt_data;
  logic [7:0]  drop_cnt;
  logic        w_en, w_ready, w_clr, w_valid, w_ovf;
  logic [1:0]  w_a, w_b;
  logic [7:0]  w_data, w_drop;
  int          checks = 0;
  int          failures = 0;
  logic [15:0] ts_m;
  logic [19:0] exp_q [8];

  always #5 clk = ~clk;

  duv_resp_monitor #(.TS_W(16), .DEPTH(8)) u_dut (
    .clk(clk), .arst(arst), .mon_en(mon_en), .out_a(out_a), .out_b(out_b),
    .evt_ready(evt_ready), .evt_valid(evt_valid), .evt_data(evt_data),
    .ovf_clr(ovf_clr), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  duv_resp_monitor #(.TS_W(4), .DEPTH(8)) u_wrap (
    .clk(clk), .arst(arst), .mon_en(w_en), .out_a(w_a), .out_b(w_b),
    .evt_ready(w_ready), .evt_valid(w_valid), .evt_data(w_data),
    .ovf_clr(w_clr), .overflow(w_ovf), .drop_cnt(w_drop)
  );

  task automatic step;
    logic e;
    e = mon_en;
    @(posedge clk);
    #1;
    if (e && !arst) ts_m = ts_m + 16'd1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    if (evt_valid !== 1'b0) begin $display("FAIL rst_valid got=%h exp=%h", evt_valid, 1'b0); failures++; end
    checks++;
    if (evt_data !== 20'h0) begin $display("FAIL rst_data got=%h exp=%h", evt_data, 20'h0); failures++; end
    checks++;
    if (overflow !== 1'b0) begin $display("FAIL rst_ovf got=%h exp=%h", overflow, 1'b0); failures++; end
    checks++;
    if (drop_cnt !== 8'h0) begin $display("FAIL rst_drop got=%h exp=%h", drop_cnt, 8'h0); failures++; end
    checks++;
    arst = 1'b0;
    mon_en = 1'b1;
    evt_ready = 1'b1;
    ts_m = 16'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (evt_valid !== 1'b0) begin $display("FAIL idle_valid got=%h exp=%h", evt_valid, 1'b0); failures++; end
      checks++;
    end
    if (overflow !== 1'b0 || drop_cnt !== 8'h0) begin
      $display("FAIL idle_ovf got=%h/%h exp=0/00", overflow, drop_cnt); failures++;
    end
    checks++;
  endtask

  task automatic test_single_change;
    while (ts_m < 16'd10) step();
    out_a = 2'b01;
    step();
    if (evt_valid !== 1'b1) begin $display("FAIL single_valid got=%h exp=%h", evt_valid, 1'b1); failures++; end
    checks++;
    if (evt_data !== 20'h000A4) begin $display("FAIL single_data got=%h exp=%h", evt_data, 20'h000A4); failures++; end
    checks++;
    step();
    if (evt_valid !== 1'b0) begin $display("FAIL single_pop got=%h exp=%h", evt_valid, 1'b0); failures++; end
    checks++;
    if (evt_data !== 20'h000A4) begin $display("FAIL single_hold got=%h exp=%h", evt_data, 20'h000A4); failures++; end
    checks++;
  endtask

  task automatic test_overflow;
    logic [15:0] t0;
    evt_ready = 1'b0;
    t0 = ts_m;
    for (int i = 0; i < 12; i++) begin
      out_b = i[0] ? 2'b00 : 2'b11;
      if (i < 8) exp_q[i] = {t0 + 16'(i), 2'b01, out_b};
      step();
    end
    if (evt_valid !== 1'b1) begin $display("FAIL ovf_valid got=%h exp=%h", evt_valid, 1'b1); failures++; end
    checks++;
    if (evt_data !== exp_q[0]) begin $display("FAIL ovf_head got=%h exp=%h", evt_data, exp_q[0]); failures++; end
    checks++;
    if (overflow !== 1'b1) begin $display("FAIL ovf_flag got=%h exp=%h", overflow, 1'b1); failures++; end
    checks++;
    if (drop_cnt !== 8'd4) begin $display("FAIL ovf_drop got=%0d exp=%0d", drop_cnt, 4); failures++; end
    checks++;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      $display("FAIL ovf_clr got=%h/%h exp=0/00", overflow, drop_cnt); failures++;
    end
    checks++;
    if (evt_data !== exp_q[0]) begin $display("FAIL clr_head got=%h exp=%h", evt_data, exp_q[0]); failures++; end
    checks++;
  endtask

  task automatic test_full_push_pop;
    logic [15:0] tn;
    evt_ready = 1'b1;
    out_b = 2'b11;
    tn = ts_m;
    step();
    evt_ready = 1'b0;
    if (evt_data !== exp_q[1]) begin $display("FAIL fpp_head got=%h exp=%h", evt_data, exp_q[1]); failures++; end
    checks++;
    if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin
      $display("FAIL fpp_drop got=%h/%h exp=0/00", overflow, drop_cnt); failures++;
    end
    checks++;
    for (int k = 0; k < 7; k++) exp_q[k] = exp_q[k+1];
    exp_q[7] = {tn, 4'b0111};
    evt_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (evt_valid !== 1'b1 || evt_data !== exp_q[k]) begin
        $display("FAIL drain_%0d got=%h:%h exp=1:%h", k, evt_valid, evt_data, exp_q[k]); failures++;
      end
      checks++;
      step();
    end
    for (int k = 0; k < 2; k++) begin
      if (evt_valid !== 1'b0 || evt_data !== exp_q[7]) begin
        $display("FAIL empty_ready got=%h:%h exp=0:%h", evt_valid, evt_data, exp_q[7]); failures++;
      end
      checks++;
      step();
    end
  endtask

  task automatic test_enable_gating;
    logic [15:0] tf;
    logic [1:0]  seq [4];
    seq = '{2'b10, 2'b11, 2'b10, 2'b11};
    mon_en = 1'b0;
    tf = ts_m;
    for (int i = 0; i < 4; i++) begin
      out_a = seq[i];
      step();
      if (evt_valid !== 1'b0) begin $display("FAIL gate_valid got=%h exp=%h", evt_valid, 1'b0); failures++; end
      checks++;
    end
    mon_en = 1'b1;
    step();
    step();
    if (evt_valid !== 1'b0) begin $display("FAIL gate_reen got=%h exp=%h", evt_valid, 1'b0); failures++; end
    checks++;
    out_a = 2'b00;
    step();
    if (evt_valid !== 1'b1 || evt_data !== {tf + 16'd2, 4'b0011}) begin
      $display("FAIL gate_ts got=%h:%h exp=1:%h", evt_valid, evt_data, {tf + 16'd2, 4'b0011}); failures++;
    end
    checks++;
    step();
    if (evt_valid !== 1'b0) begin $display("FAIL gate_pop got=%h exp=%h", evt_valid, 1'b0); failures++; end
    checks++;
  endtask

  task automatic test_glitch;
    logic [15:0] t;
    evt_ready = 1'b0;
`ifdef MON_GLITCH_FILTER_EN
    out_b = 2'b01;
    step();
    out_b = 2'b11;
    step();
    step();
    if (evt_valid !== 1'b0) begin $display("FAIL glitch_pulse got=%h exp=%h", evt_valid, 1'b0); failures++; end
    checks++;
    out_b = 2'b10;
    t = ts_m;
    step();
    if (evt_valid !== 1'b0) begin $display("FAIL glitch_first got=%h exp=%h", evt_valid, 1'b0); failures++; end
    checks++;
    step();
    if (evt_valid !== 1'b1 || evt_data !== {t + 16'd1, 4'b0010}) begin
      $display("FAIL glitch_hold got=%h:%h exp=1:%h", evt_valid, evt_data, {t + 16'd1, 4'b0010}); failures++;
    end
    checks++;
    evt_ready = 1'b1;
    step();
`else
    out_b = 2'b01;
    t = ts_m;
    step();
    out_b = 2'b11;
    step();
    if (evt_valid !== 1'b1 || evt_data !== {t, 4'b0001}) begin
      $display("FAIL pulse_rise got=%h:%h exp=1:%h", evt_valid, evt_data, {t, 4'b0001}); failures++;
    end
    checks++;
    evt_ready = 1'b1;
    step();
    if (evt_valid !== 1'b1 || evt_data !== {t + 16'd1, 4'b0011}) begin
      $display("FAIL pulse_fall got=%h:%h exp=1:%h", evt_valid, evt_data, {t + 16'd1, 4'b0011}); failures++;
    end
    checks++;
    step();
`endif
    if (evt_valid !== 1'b0) begin $display("FAIL glitch_drain got=%h exp=%h", evt_valid, 1'b0); failures++; end
    checks++;
  endtask

  task automatic test_reset_mid;
    evt_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      out_b = out_b ^ 2'b01;
      step();
    end
    if (evt_valid !== 1'b1) begin $display("FAIL mid_fill got=%h exp=%h", evt_valid, 1'b1); failures++; end
    checks++;
    evt_ready = 1'b1;
    arst = 1'b1;
    #1;
    if (evt_valid !== 1'b0 || evt_data !== 20'h0) begin
      $display("FAIL mid_rst got=%h:%h exp=0:00000", evt_valid, evt_data); failures++;
    end
    checks++;
    mon_en = 1'b0;
    evt_ready = 1'b0;
    out_a = 2'b00;
    out_b = 2'b00;
    @(posedge clk);
    #1;
    arst = 1'b0;
  endtask

  task automatic test_wrap;
    w_en = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    w_a = 2'b01;
    @(posedge clk);
    #1;
    if (w_valid !== 1'b1 || w_data !== 8'hF4) begin
      $display("FAIL wrap_15 got=%h:%h exp=1:f4", w_valid, w_data); failures++;
    end
    checks++;
    w_a = 2'b10;
    @(posedge clk);
    #1;
    if (w_data !== 8'hF4) begin $display("FAIL wrap_hold got=%h exp=%h", w_data, 8'hF4); failures++; end
    checks++;
    w_ready = 1'b1;
    @(posedge clk);
    #1;
    if (w_valid !== 1'b1 || w_data !== 8'h08) begin
      $display("FAIL wrap_0 got=%h:%h exp=1:08", w_valid, w_data); failures++;
    end
    checks++;
    @(posedge clk);
    #1;
    if (w_valid !== 1'b0) begin $display("FAIL wrap_empty got=%h exp=%h", w_valid, 1'b0); failures++; end
    checks++;
  endtask

  initial begin
    arst = 1'b1;
    mon_en = 1'b0;
    evt_ready = 1'b0;
    ovf_clr = 1'b0;
    out_a = 2'b00;
    out_b = 2'b00;
    w_en = 1'b0;
    w_ready = 1'b0;
    w_clr = 1'b0;
    w_a = 2'b00;
    w_b = 2'b00;
    ts_m = 16'd0;
    test_reset();
    test_single_change();
    test_overflow();
    test_full_push_pop();
    test_enable_gating();
    test_glitch();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
